// File: rtl/spi_responder_pkg.sv
// Shared constants and state encoding for the SPI mode-0 responder.
package spi_responder_pkg;

  localparam int unsigned SPI_DATA_WIDTH = 8;
  localparam int unsigned SPI_REG_WIDTH  = 16;

  localparam logic [7:0] SPI_FILL_BYTE = 8'hFF;

  localparam logic SPI_RSP_IDLE  = 1'b0;
  localparam logic SPI_RSP_SHIFT = 1'b1;

  typedef enum logic {
    StIdle  = SPI_RSP_IDLE,
    StShift = SPI_RSP_SHIFT
  } spi_rsp_state_e;

endpackage

// File: rtl/spi_responder_if.sv
// Bus-side and core-side signals of the SPI responder, grouped for one port.
interface spi_responder_if #(
  parameter int unsigned DATA_WIDTH = spi_responder_pkg::SPI_DATA_WIDTH,
  parameter int unsigned REG_WIDTH  = spi_responder_pkg::SPI_REG_WIDTH
);

  logic                  sck;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic [REG_WIDTH-1:0]  word_count;
  logic                  tx_underrun;

  modport slave (
    input  sck, cs, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, busy, word_count, tx_underrun
  );

  modport master (
    output sck, cs, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, busy, word_count, tx_underrun
  );

endinterface

// File: rtl/spi_sync.sv
// 2-FF synchroniser plus one edge-detect stage; level is the edge-stage output
// so that level and the detected edge take effect on the same clock.
module spi_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_800k,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_800k or posedge rst) begin
    if (rst) begin
      sync_q <= {3{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  assign level = sync_q[2];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 target: oversamples sck/cs/mosi, assembles rx words and
// serialises core-supplied tx words onto miso, MSB first.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int unsigned           REG_WIDTH  = SPI_REG_WIDTH,
  parameter logic [DATA_WIDTH-1:0] FILL_BYTE  = SPI_FILL_BYTE
) (
  input logic           clk_800k,
  input logic           rst,
  spi_responder_if.slave bus
);

  localparam int unsigned CntWidth = $clog2(DATA_WIDTH);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_sync #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk_800k (clk_800k),
    .rst      (rst),
    .din      (bus.sck),
    .level    (sck_level),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  spi_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk_800k (clk_800k),
    .rst      (rst),
    .din      (bus.cs),
    .level    (cs_level),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk_800k (clk_800k),
    .rst      (rst),
    .din      (bus.mosi),
    .level    (mosi_level),
    .rise     (mosi_rise),
    .fall     (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_level, mosi_rise, mosi_fall};

  spi_rsp_state_e        state_q, state_d;
  logic [CntWidth-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [REG_WIDTH-1:0]  word_count_q, word_count_d;
  logic                  reload_q, reload_d;
  logic [DATA_WIDTH-1:0] shift_out_q, shift_out_d;
  logic [DATA_WIDTH-1:0] holding_q, holding_d;
  logic                  full_q, full_d;
  logic                  underrun_q, underrun_d;
  logic [1:0]            settle_q;
  logic                  armed_q;
  logic                  load;
  logic                  tx_write;
  logic [DATA_WIDTH-1:0] rx_word;

  // A cs already low when reset releases must not start a transaction: the
  // block arms only once the flushed synchroniser has shown cs high.
  always_ff @(posedge clk_800k or posedge rst) begin
    if (rst) begin
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      if (settle_q != 2'd3) begin
        settle_q <= settle_q + 2'd1;
      end
      if (settle_q == 2'd3 && cs_level) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign tx_write = bus.tx_valid & ~full_q;
  assign rx_word  = {rx_shift_q[DATA_WIDTH-2:0], mosi_level};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    word_count_d = word_count_q;
    reload_d     = reload_q;
    shift_out_d  = shift_out_q;
    holding_d    = holding_q;
    full_d       = full_q;
    underrun_d   = underrun_q;
    load         = 1'b0;

    if (cs_rise) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      reload_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall && armed_q) begin
            state_d      = StShift;
            bit_cnt_d    = '0;
            word_count_d = '0;
            reload_d     = 1'b0;
            underrun_d   = 1'b0;
            load         = 1'b1;
          end
        end
        StShift: begin
          if (sck_rise) begin
            rx_shift_d = rx_word;
            if (bit_cnt_q == CntWidth'(DATA_WIDTH - 1)) begin
              rx_data_d    = rx_word;
              rx_valid_d   = 1'b1;
              word_count_d = word_count_q + REG_WIDTH'(1);
              bit_cnt_d    = '0;
              reload_d     = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CntWidth'(1);
            end
          end
          if (sck_fall) begin
            if (reload_q) begin
              load     = 1'b1;
              reload_d = 1'b0;
            end else begin
              shift_out_d = {shift_out_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Load consumes the old holding contents; a same-cycle write lands after.
    if (load) begin
      shift_out_d = full_q ? holding_q : FILL_BYTE;
      full_d      = 1'b0;
      if (!full_q) begin
        underrun_d = 1'b1;
      end
    end
    if (tx_write) begin
      holding_d = bus.tx_data;
      full_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_800k or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      word_count_q <= '0;
      reload_q     <= 1'b0;
      shift_out_q  <= '0;
      holding_q    <= '0;
      full_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      word_count_q <= word_count_d;
      reload_q     <= reload_d;
      shift_out_q  <= shift_out_d;
      holding_q    <= holding_d;
      full_q       <= full_d;
      underrun_q   <= underrun_d;
    end
  end

  assign bus.busy        = armed_q & ~cs_level;
  assign bus.miso        = bus.busy ? shift_out_q[DATA_WIDTH-1] : 1'b0;
  assign bus.tx_ready    = ~full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.word_count  = word_count_q;
  assign bus.tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_responder.sv
// Scoreboard bench for spi_responder: an initiator model drives mode-0 words,
// a core model feeds tx words, and a monitor checks every rx_valid pulse.
module tb_spi_responder;

  localparam int Half = 40;  // 4 clk_800k periods per sck phase

  logic clk_800k = 1'b0;
  logic rst;

  always #5 clk_800k = ~clk_800k;

  spi_responder_if #(.DATA_WIDTH(8), .REG_WIDTH(8)) bus ();

  spi_responder #(
    .DATA_WIDTH (8),
    .REG_WIDTH  (8),
    .FILL_BYTE  (8'hFF)
  ) dut (
    .clk_800k (clk_800k),
    .rst      (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] mosi_q[$];
  logic [7:0] exp_wc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

  // rx monitor: pops one expected word per rx_valid pulse
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk_800k);
      #1;
      if (bus.rx_valid) begin
        check("rx_pulse_gap", 32'(prev), 32'd0);
        if (exp_rx.size() == 0) begin
          check("rx_unexpected", 32'(bus.rx_valid), 32'd0);
        end else begin
          check("rx_data", 32'(bus.rx_data), 32'(exp_rx.pop_front()));
          exp_wc = exp_wc + 8'd1;
          check("word_count", 32'(bus.word_count), 32'(exp_wc));
        end
      end
      prev = bus.rx_valid;
    end
  end

  task automatic core_write(input logic [7:0] d);
    int n;
    n = 0;
    @(posedge clk_800k);
    #1;
    while (!bus.tx_ready && n < 2000) begin
      @(posedge clk_800k);
      #1;
      n++;
    end
    if (!bus.tx_ready) begin
      check("tx_ready_timeout", 32'(bus.tx_ready), 32'd1);
      return;
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    exp_tx.push_back(d);
    @(posedge clk_800k);
    #1;
    bus.tx_valid = 1'b0;
  endtask

  // cs rises together with the final sck fall so no trailing reload happens
  task automatic spi_word(input logic [7:0] tx, input int nbits, input bit last,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = tx[7-i];
      #(Half);
      bus.sck = 1'b1;
      rx = {rx[6:0], bus.miso};
      #(Half);
      if (last && i == nbits - 1) bus.cs = 1'b1;
      bus.sck = 1'b0;
    end
  endtask

  task automatic spi_xact(input int n);
    logic [7:0] w, got, exp;
    @(posedge clk_800k);
    #($urandom_range(1, 4));
    exp_wc = 8'd0;
    bus.cs = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (mosi_q.size() > 0) w = mosi_q.pop_front();
      else w = 8'($urandom);
      exp_rx.push_back(w);
      spi_word(w, 8, i == n - 1, got);
      exp = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'hFF;
      check("miso_word", 32'(got), 32'(exp));
    end
    repeat (8) @(posedge clk_800k);
    #1;
    check("word_count_end", 32'(bus.word_count), 32'(n % 256));
  endtask

  initial begin
    logic [7:0] got;
    rst          = 1'b1;
    bus.sck      = 1'b0;
    bus.cs       = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    exp_wc       = 8'd0;
    repeat (3) @(posedge clk_800k);
    #1;
    check("rst_miso", 32'(bus.miso), 32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_word_count", 32'(bus.word_count), 32'd0);
    check("rst_underrun", 32'(bus.tx_underrun), 32'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk_800k);

    // single word
    mosi_q.push_back(8'h3C);
    core_write(8'hA5);
    spi_xact(1);
    check("single_underrun", 32'(bus.tx_underrun), 32'd0);

    // back-to-back, second word written while the first is shifting
    mosi_q.push_back(8'hF0);
    mosi_q.push_back(8'h0F);
    core_write(8'h11);
    fork
      spi_xact(2);
      begin
        repeat (10) @(posedge clk_800k);
        core_write(8'h22);
      end
    join
    check("b2b_underrun", 32'(bus.tx_underrun), 32'd0);

    // underrun, then cleared by the next cs fall with a word held
    spi_xact(2);
    check("underrun_set", 32'(bus.tx_underrun), 32'd1);
    core_write(8'hC3);
    spi_xact(1);
    check("underrun_clear", 32'(bus.tx_underrun), 32'd0);

    // abort after 5 bits
    @(posedge clk_800k);
    #2;
    exp_wc = 8'd0;
    bus.cs = 1'b0;
    spi_word(8'h6B, 5, 1'b1, got);
    repeat (8) @(posedge clk_800k);
    #1;
    check("abort_word_count", 32'(bus.word_count), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    core_write(8'h5A);
    spi_xact(1);

    // reset after 3 bits with cs held low
    @(posedge clk_800k);
    #3;
    bus.cs = 1'b0;
    spi_word(8'hE7, 3, 1'b0, got);
    #13;
    rst = 1'b1;
    repeat (2) @(posedge clk_800k);
    #1;
    check("mid_rst_miso", 32'(bus.miso), 32'd0);
    check("mid_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("mid_rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_word_count", 32'(bus.word_count), 32'd0);
    check("mid_rst_underrun", 32'(bus.tx_underrun), 32'd0);
    #2;
    rst = 1'b0;
    exp_tx.delete();
    spi_word(8'h81, 8, 1'b0, got);
    repeat (4) @(posedge clk_800k);
    #1;
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("post_rst_miso", 32'(bus.miso), 32'd0);
    bus.cs = 1'b1;
    repeat (10) @(posedge clk_800k);
    core_write(8'h96);
    spi_xact(1);

    // 256 random words at minimum sck timing; word_count wraps to 0
    core_write(8'($urandom));
    fork
      for (int i = 0; i < 255; i++) core_write(8'($urandom));
      spi_xact(256);
    join
    check("stress_underrun", 32'(bus.tx_underrun), 32'd0);
    check("stress_rx_drained", 32'(exp_rx.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
